// File: rtl/csa_seq_mult.sv
// Sequential carry-save multiplier front end: folds one shifted partial product per
// cycle through a 3:2 compressor row and hands the sum/carry pair to the KPG CLA adder.
module csa_seq_mult #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   sum_row,
  output logic [2*WIDTH-1:0]   carry_row,
  output logic [7:0]           cin_kpg,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [KW-1:0]     k;
  logic [PW-1:0]     pp, s_nxt, c_nxt;
  logic              last_step;

  // Kill code for the adder's carry-in; constant even while in reset.
  assign cin_kpg   = 8'h6B;
  assign last_step = (k == KW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ACCUM;
      ACCUM:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // One 3:2 compressor row; the carry MSB shifted out is dropped (mod 2^PW).
  always_comb begin
    pp    = b_reg[k] ? (a_reg << k) : '0;
    s_nxt = sum_row ^ carry_row ^ pp;
    c_nxt = ((sum_row & carry_row) | (sum_row & pp) | (carry_row & pp)) << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      k         <= '0;
      sum_row   <= '0;
      carry_row <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= PW'(a);
            b_reg     <= b;
            k         <= '0;
            sum_row   <= '0;
            carry_row <= '0;
          end
        end
        ACCUM: begin
          sum_row   <= s_nxt;
          carry_row <= c_nxt;
          if (!last_step) k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/csa_seq_mult.md
Name: csa_seq_mult

Overview:
- Sequential carry-save multiplier front end for the Dadda multiplier datapath.
- Accepts one unsigned WIDTH x WIDTH operand pair and adds one shifted partial product per cycle through a 3:2 compressor row.
- Presents the final sum/carry row pair to the 32-bit KPG carry-lookahead adder, which resolves it into the product.
- Also drives that adder's 8-bit KPG carry-in with the "kill" code.

Parameters:
- WIDTH, 16, operand width; product and row width is 2*WIDTH (32 at default, matching the CLA adder).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  sum_row/carry_row hold a complete result.
- out_ready  input  1  downstream adder stage consumes the result.
- sum_row  output  2*WIDTH  carry-save sum vector.
- carry_row  output  2*WIDTH  carry-save carry vector, already left-aligned; the adder adds it directly.
- cin_kpg  output  8  constant 8'h6B (ASCII "k"), the carry-in code for the adder's xin.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, sum_row=0, carry_row=0, out_valid=0, busy=0, in_ready=1.
  - Internal a/b registers and step counter = 0.
  - cin_kpg is always 8'h6B, including during reset.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture a (zero-extended to 2*WIDTH) and b, clear sum/carry, counter k=0, go to ACCUM.
  - in_valid without the handshake has no effect.
- ACCUM, once per cycle for k = 0..WIDTH-1:
  - pp = b_reg[k] ? (a_ext << k) : 0.
  - s' = sum ^ carry ^ pp.
  - c' = ((sum&carry) | (sum&pp) | (carry&pp)) << 1, with the bit shifted out of the MSB discarded.
  - Register s' and c', then k = k+1.
  - After the step with k = WIDTH-1, go to DONE.
  - ACCUM lasts exactly WIDTH cycles; in_ready=0 throughout, and in_valid is ignored.
- DONE:
  - out_valid=1; sum_row and carry_row are stable and unchanged while out_valid=1 && out_ready=0.
  - On out_ready: out_valid drops the next cycle and the state returns to IDLE.
  - in_ready rises the cycle after the handshake. The same-cycle DONE->ACCUM bypass is intentionally not supported.
- Latency: operand handshake at edge N gives out_valid=1 from edge N+WIDTH; result in DONE after exactly WIDTH ACCUM cycles.
- Throughput: one product per WIDTH+2 cycles minimum.
- Arithmetic invariant: (sum_row + carry_row) mod 2^(2*WIDTH) == a*b.
  - Exact, because a*b < 2^(2*WIDTH); discarded MSB carries do not affect the modulo sum.
  - The invariant also holds for the partial state after every ACCUM step k (sum over the first k+1 partial products).
- b_reg bits are consumed LSB first; the counter must not wrap past WIDTH-1.
- Zero operand: still takes WIDTH cycles; both rows end at 0.
- Reset mid-ACCUM or mid-DONE: the result is discarded; the next result comes only from a fresh handshake.
- out_ready asserted outside DONE is ignored.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset, then a=16'h0003, b=16'h0005 handshake → out_valid exactly 16 cycles later; sum_row+carry_row (mod 2^32) = 32'h0000000F; cin_kpg=8'h6B throughout.
- a=16'hFFFF, b=16'hFFFF → row sum = 32'hFFFE0001; feeding the rows and cin_kpg into the CLA adder gives si=32'hFFFE0001 and xout="k" or "p" (no overflow "g").
- a=16'h1234, b=16'h0000 and a=0, b=16'hABCD → sum_row=0, carry_row=0, still 16-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → rows and out_valid stable; in_valid pulses are ignored and in_ready=0. Release → out_valid falls next cycle; in_ready=1 the cycle after the handshake.
- Assert rst at ACCUM step 7 of a=16'h00FF, b=16'h0F0F → outputs return to reset values immediately. A new pair a=16'h0002, b=16'h0002 then yields row sum 32'h00000004.
- Back-to-back random sweep (1000 pairs, random out_ready) → every result equals a*b mod 2^32; no pair lost or duplicated.
